// File: rtl/axil_pkg.sv
// Shared AXI4-lite definitions: response codes and the byte-strobe merge
// used by register-bank slaves (data words up to 64 bits).
package axil_pkg;

    typedef enum logic [1:0] {
        AXIL_RESP_OKAY   = 2'b00,
        AXIL_RESP_SLVERR = 2'b10,
        AXIL_RESP_DECERR = 2'b11
    } axil_resp_e;

    function automatic logic [63:0] axil_strb_merge(
        input logic [63:0] old_word,
        input logic [63:0] new_word,
        input logic [7:0]  strb
    );
        logic [63:0] merged;
        merged = old_word;
        for (int unsigned b = 0; b < 8; b++) begin
            if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_aw_w_join.sv
// AW/W join for the AXI4-lite register slave: captures the address and data
// channels independently and issues do_write once both halves are present.
module axil_aw_w_join
    import axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_done,
    input  logic                  bvalid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic                  do_write,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [STRB_WIDTH-1:0] wr_strb
);

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  aw_hs;
    logic                  w_hs;

    assign awready  = init_done && !aw_held && !bvalid;
    assign wready   = init_done && !w_held && !bvalid;
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign do_write = (aw_held || aw_hs) && (w_held || w_hs) && !bvalid;

    // A half arriving in the completing cycle bypasses its holding register.
    assign wr_addr  = aw_held ? aw_addr_q : awaddr;
    assign wr_data  = w_held  ? w_data_q  : wdata;
    assign wr_strb  = w_held  ? w_strb_q  : wstrb;

    always_ff @(posedge clk) begin
        if (!rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (do_write) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-lite register bank with byte-strobe writes and per-register write pulses.
// Define AXIL_REG_SLAVE_DECERR_EN to answer out-of-range accesses with DECERR.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned           NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
    input  logic [2:0]                     s_axil_awprot,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]          s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic [2:0]                     s_axil_arprot,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    output logic [DATA_WIDTH-1:0]          s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr
);

    localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);

`ifdef AXIL_REG_SLAVE_DECERR_EN
    localparam axil_resp_e MISS_RESP = AXIL_RESP_DECERR;
`else
    localparam axil_resp_e MISS_RESP = AXIL_RESP_OKAY;
`endif

    logic                  init_done;
    logic                  do_write;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  wr_hit;
    logic                  rd_hit;
    logic                  ar_hs;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  unused;

    assign unused = ^{s_axil_awprot, s_axil_arprot};

    axil_aw_w_join #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_join (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .bvalid    (s_axil_bvalid),
        .awaddr    (s_axil_awaddr),
        .awvalid   (s_axil_awvalid),
        .awready   (s_axil_awready),
        .wdata     (s_axil_wdata),
        .wstrb     (s_axil_wstrb),
        .wvalid    (s_axil_wvalid),
        .wready    (s_axil_wready),
        .do_write  (do_write),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb)
    );

    assign wr_idx         = wr_addr >> ADDR_LSB;
    assign rd_idx         = s_axil_araddr >> ADDR_LSB;
    assign wr_hit         = {1'b0, wr_idx} < (ADDR_WIDTH + 1)'(NUM_REGS);
    assign rd_hit         = {1'b0, rd_idx} < (ADDR_WIDTH + 1)'(NUM_REGS);
    assign s_axil_arready = init_done && !s_axil_rvalid;
    assign ar_hs          = s_axil_arvalid && s_axil_arready;

    // Out-of-range index matches no register, so the mux falls through to zero.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == ADDR_WIDTH'(i)) rd_word = regs[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            init_done     <= 1'b0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= '0;
            s_axil_rvalid <= 1'b0;
            s_axil_rresp  <= '0;
            s_axil_rdata  <= '0;
            reg_wr        <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
        end else begin
            init_done <= 1'b1;
            reg_wr    <= '0;

            if (do_write) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_hit ? AXIL_RESP_OKAY : MISS_RESP;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (wr_idx == ADDR_WIDTH'(i)) begin
                        regs[i]   <= DATA_WIDTH'(axil_strb_merge(64'(regs[i]), 64'(wr_data), 8'(wr_strb)));
                        reg_wr[i] <= 1'b1;
                    end
                end
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end

            // Reads sample regs before this edge's write lands: read-old-value.
            if (ar_hs) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= rd_word;
                s_axil_rresp  <= rd_hit ? AXIL_RESP_OKAY : MISS_RESP;
            end else if (s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-lite slave register bank.
- Sits directly downstream of an AXI-lite master/interconnect. Its s_axil_* port is the interface the team's AXI-lite slave formal checker binds to.
- Provides NUM_REGS read/write registers with byte-strobe writes and per-register write pulses.
- Must satisfy every AXI-lite slave handshake, reset and outstanding-count property the team's checker enforces.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (32 or 64).
- ADDR_WIDTH, 16, address bus width in bits.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- NUM_REGS, 16, number of registers (1..2^(ADDR_WIDTH-log2(STRB_WIDTH))).
- RESET_VALUE, 0, reset value of every register (DATA_WIDTH bits).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (rst==0 resets)
- s_axil_awaddr/awprot/awvalid  input  ADDR_WIDTH/3/1  write address channel
- s_axil_awready  output  1
- s_axil_wdata/wstrb/wvalid  input  DATA_WIDTH/STRB_WIDTH/1  write data channel
- s_axil_wready  output  1
- s_axil_bresp/bvalid  output  2/1  write response channel
- s_axil_bready  input  1
- s_axil_araddr/arprot/arvalid  input  ADDR_WIDTH/3/1  read address channel
- s_axil_arready  output  1
- s_axil_rdata/rresp/rvalid  output  DATA_WIDTH/2/1  read data channel
- s_axil_rready  input  1
- reg_q  output  NUM_REGS*DATA_WIDTH  flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
- reg_wr  output  NUM_REGS  one-cycle pulse, high the cycle after register i is written

Behaviour:
- Reset (rst==0 at an edge):
  - awready, wready, arready, bvalid and rvalid become 0; bresp, rresp and rdata become 0.
  - Held AW/W are dropped; every reg_q word becomes RESET_VALUE; reg_wr becomes 0.
  - Reset mid-transaction discards it silently; no response is issued afterwards.
- init_done register: cleared by reset, set at the first edge with rst==1. All readies are gated by init_done, so every ready is 0 in the cycle after any reset cycle.
- Decode:
  - idx = addr >> log2(STRB_WIDTH); low address bits are ignored.
  - Address is in range iff idx < NUM_REGS. awprot and arprot are ignored.
- Write path:
  - AW and W are accepted independently into holding registers aw_held and w_held.
  - awready = init_done && !aw_held && !bvalid; wready = init_done && !w_held && !bvalid.
  - do_write = (aw_held || aw handshake) && (w_held || w handshake) && !bvalid.
  - At a do_write edge: target register lanes with wstrb[b]==1 are updated; bvalid is set; bresp is set; both held flags clear; reg_wr[idx] is set for one cycle.
  - Latency: AW and W handshaking in the same cycle N give bvalid=1 and the updated reg_q in cycle N+1.
  - At most one write is outstanding. bvalid and bresp stay stable until bready; the cycle after a B handshake, the readies reassert (if init_done).
- Read path:
  - arready = init_done && !rvalid.
  - An AR handshake at edge N latches rdata (current reg_q[idx], or 0 if out of range) and rresp; rvalid=1 in cycle N+1.
  - rdata, rresp and rvalid are stable until rready. Read and write paths are fully independent.
- Simultaneous write and read to the same register in one cycle: the read returns the pre-write value.
- A write with wstrb==0 is a legal no-op write: it returns OKAY and still pulses reg_wr.

Optional Feature:
- Macro AXIL_REG_SLAVE_DECERR_EN.
- Defined: an out-of-range write changes no register and produces no reg_wr pulse, with bresp=2'b11 (DECERR). An out-of-range read returns rdata=0, rresp=2'b11.
- Undefined: out-of-range accesses return OKAY (2'b00). Writes are dropped and reads return 0.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package axil_pkg: response codes AXIL_RESP_OKAY=2'b00, AXIL_RESP_SLVERR=2'b10, AXIL_RESP_DECERR=2'b11, plus a byte-strobe merge function.
- Natural sub-module: axil_aw_w_join. It holds the AW/W holding registers and the ready generation, and produces do_write, waddr, wdata and wstrb.
- The top level keeps the register array, the read path and response generation.

Test Plan:
- Reset release: hold rst=0 for 3 cycles, then rst=1 → all readies 0 in the first cycle after reset; awready/wready/arready 1 the next cycle; reg_q all RESET_VALUE.
- Same-cycle write: awaddr=0x8, wdata=0xDEADBEEF, wstrb=4'hF, bready=1 → bvalid in cycle N+1, bresp=0; reg_q[2]=0xDEADBEEF; reg_wr[2] pulses once.
- Split write under backpressure: W accepted (wdata=0x000000AA, wstrb=4'h1) 3 cycles before AW=0x4, bready=0 for 4 cycles → wready stays 0 while held; bvalid and bresp stable; only byte 0 of reg_q[1] changes; the readies return the cycle after the B handshake.
- Read under backpressure: read 0x8 after the write above with rready=0 for 5 cycles → rvalid stays 1; rdata=0xDEADBEEF stable; arready=0 until the R handshake.
- Out of range with NUM_REGS=16: write and read 0x40 → with AXIL_REG_SLAVE_DECERR_EN, bresp=rresp=2'b11, rdata=0 and no reg_wr; without the macro, resp=2'b00.
- Reset mid-operation: AW accepted, W pending, rst=0 for one cycle → no bvalid is ever produced; the next full write completes normally.
